// File: rtl/ufp_mem_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and load/store.
// Data has priority, with a starvation limit so that fetch is eventually granted.
module ufp_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_flush,

    input  logic [31:0] i_addr,
    input  logic [3:0]  i_rmask,
    output logic [31:0] i_rdata,
    output logic        i_resp,

    input  logic [31:0] d_addr,
    input  logic [3:0]  d_rmask,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,

    output logic [31:0] dfp_addr,
    output logic [3:0]  dfp_rmask,
    output logic [3:0]  dfp_wmask,
    output logic [31:0] dfp_wdata,
    input  logic [31:0] dfp_rdata,
    input  logic        dfp_resp,

    output logic        arb_busy
);

    localparam int unsigned            CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic             i_vld_q,   i_vld_d;
    logic [31:0]      i_addr_q,  i_addr_d;
    logic             d_vld_q,   d_vld_d;
    logic [31:0]      d_addr_q,  d_addr_d;
    logic [3:0]       d_rmask_q, d_rmask_d;
    logic [3:0]       d_wmask_q, d_wmask_d;
    logic [31:0]      d_wdata_q, d_wdata_d;
    logic             drop_q,    drop_d;
    logic [CNT_W-1:0] starve_q,  starve_d;

    logic in_idle;
    logic i_req;
    logic d_req;
    logic starved;
    logic grant_i;
    logic grant_d;

    assign in_idle = (state_q == ST_IDLE);
    assign i_req   = |i_rmask;
    assign d_req   = |d_rmask || |d_wmask;
    assign starved = (starve_q == CNT_MAX);

    // Data wins unless fetch has already waited through STARVE_LIMIT data grants.
    assign grant_d = in_idle && d_vld_q && !(i_vld_q && starved);
    assign grant_i = in_idle && i_vld_q && !grant_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        i_vld_d   = i_vld_q;
        i_addr_d  = i_addr_q;
        d_vld_d   = d_vld_q;
        d_addr_d  = d_addr_q;
        d_rmask_d = d_rmask_q;
        d_wmask_d = d_wmask_q;
        d_wdata_d = d_wdata_q;
        drop_d    = drop_q;
        starve_d  = starve_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    state_d = ST_BUSY_D;
                end else if (grant_i) begin
                    state_d = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (dfp_resp) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new fetch pulse outranks both the grant and the flush, so it survives a flush.
        if (i_req) begin
            i_vld_d  = 1'b1;
            i_addr_d = i_addr;
        end else if (grant_i || fetch_flush) begin
            i_vld_d = 1'b0;
        end

        if (d_req) begin
            d_vld_d   = 1'b1;
            d_addr_d  = d_addr;
            d_rmask_d = d_rmask;
            d_wmask_d = d_wmask;
            d_wdata_d = d_wdata;
        end else if (grant_d) begin
            d_vld_d = 1'b0;
        end

        if (state_q == ST_BUSY_I) begin
            if (dfp_resp) begin
                drop_d = 1'b0;
            end else if (fetch_flush) begin
                drop_d = 1'b1;
            end
        end else begin
            drop_d = 1'b0;
        end

        if (grant_i || (in_idle && !i_vld_q)) begin
            starve_d = '0;
        end else if (grant_d && i_vld_q && !starved) begin
            starve_d = starve_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= ST_IDLE;
            i_vld_q  <= 1'b0;
            d_vld_q  <= 1'b0;
            drop_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            i_vld_q  <= i_vld_d;
            d_vld_q  <= d_vld_d;
            drop_q   <= drop_d;
            starve_q <= starve_d;
        end
    end

    // NOTE: request payloads are qualified by their valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        i_addr_q  <= i_addr_d;
        d_addr_q  <= d_addr_d;
        d_rmask_q <= d_rmask_d;
        d_wmask_q <= d_wmask_d;
        d_wdata_q <= d_wdata_d;
    end

    always_comb begin
        dfp_addr  = grant_i ? i_addr_q : d_addr_q;
        dfp_rmask = grant_d ? d_rmask_q : (grant_i ? 4'hF : 4'h0);
        dfp_wmask = grant_d ? d_wmask_q : 4'h0;
        dfp_wdata = d_wdata_q;
    end

    // Responses are combinational; a flushed fetch response is swallowed.
    assign i_rdata  = dfp_rdata;
    assign d_rdata  = dfp_rdata;
    assign i_resp   = (state_q == ST_BUSY_I) && dfp_resp && !drop_q && !fetch_flush;
    assign d_resp   = (state_q == ST_BUSY_D) && dfp_resp;
    assign arb_busy = !in_idle;

endmodule

// File: tb/tb_ufp_mem_arbiter.sv
// Directed and randomized checks of ufp_mem_arbiter against a transaction-level model
// of pending requests, the one outstanding transaction and the starvation rule.
module tb_ufp_mem_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_flush;
    logic [31:0] i_addr;
    logic [3:0]  i_rmask;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic [31:0] d_addr;
    logic [3:0]  d_rmask;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic [31:0] dfp_addr;
    logic [3:0]  dfp_rmask;
    logic [3:0]  dfp_wmask;
    logic [31:0] dfp_wdata;
    logic [31:0] dfp_rdata;
    logic        dfp_resp;
    logic        arb_busy;

    ufp_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_flush (fetch_flush),
        .i_addr      (i_addr),
        .i_rmask     (i_rmask),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_addr      (d_addr),
        .d_rmask     (d_rmask),
        .d_wmask     (d_wmask),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .dfp_addr    (dfp_addr),
        .dfp_rmask   (dfp_rmask),
        .dfp_wmask   (dfp_wmask),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .arb_busy    (arb_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: waiting requests, owner of the outstanding transaction (0 none, 1 fetch, 2 data).
    logic        m_ivld, m_dvld, m_drop;
    logic [31:0] m_iaddr, m_daddr, m_dwd;
    logic [3:0]  m_drm, m_dwm;
    int          m_owner, m_consec, m_granted, m_wait;

    logic [3:0]  o_rmask, o_wmask;
    logic [31:0] o_addr, o_wdata, o_irdata, o_drdata;
    logic        o_iresp, o_dresp, o_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ivld = 1'b0; m_dvld = 1'b0; m_drop = 1'b0;
        m_iaddr = '0; m_daddr = '0; m_dwd = '0; m_drm = '0; m_dwm = '0;
        m_owner = 0; m_consec = 0; m_granted = 0; m_wait = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_flush = 1'b0; i_rmask = '0; d_rmask = '0; d_wmask = '0;
        dfp_resp = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0; dfp_rdata = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
    task automatic step(input logic fl, input logic [3:0] im, input logic [31:0] ia,
                        input logic [3:0] drm, input logic [3:0] dwm, input logic [31:0] da,
                        input logic [31:0] wd, input logic rsp, input logic [31:0] rd);
        int   g;
        logic e_iresp, e_dresp;
        fetch_flush = fl; i_rmask = im; i_addr = ia;
        d_rmask = drm; d_wmask = dwm; d_addr = da; d_wdata = wd;
        dfp_resp = rsp; dfp_rdata = rd;

        g = 0;
        if (m_owner == 0) begin
            if (m_dvld && !(m_ivld && m_consec >= STARVE_LIMIT)) g = 2;
            else if (m_ivld) g = 1;
        end
        e_iresp = (m_owner == 1) && rsp && !m_drop && !fl;
        e_dresp = (m_owner == 2) && rsp;

        #4;
        o_rmask = dfp_rmask; o_wmask = dfp_wmask; o_addr = dfp_addr; o_wdata = dfp_wdata;
        o_iresp = i_resp; o_irdata = i_rdata; o_dresp = d_resp; o_drdata = d_rdata; o_busy = arb_busy;

        check("arb_busy", 32'(o_busy), 32'(m_owner != 0));
        check("i_resp", 32'(o_iresp), 32'(e_iresp));
        check("d_resp", 32'(o_dresp), 32'(e_dresp));
        if (g == 2) begin
            check("dfp_rmask_d", 32'(o_rmask), 32'(m_drm));
            check("dfp_wmask_d", 32'(o_wmask), 32'(m_dwm));
            check("dfp_addr_d", o_addr, m_daddr);
            if (m_dwm != 4'h0) check("dfp_wdata", o_wdata, m_dwd);
        end else if (g == 1) begin
            check("dfp_rmask_i", 32'(o_rmask), 32'h0000000F);
            check("dfp_wmask_i", 32'(o_wmask), 32'h0);
            check("dfp_addr_i", o_addr, m_iaddr);
        end else begin
            check("dfp_rmask_quiet", 32'(o_rmask), 32'h0);
            check("dfp_wmask_quiet", 32'(o_wmask), 32'h0);
        end
        if (e_iresp) check("i_rdata", o_irdata, rd);
        if (e_dresp) check("d_rdata", o_drdata, rd);

        if (m_owner == 0) begin
            if (!m_ivld) m_consec = 0;
            if (g == 2) begin
                if (m_ivld && m_consec < STARVE_LIMIT) m_consec++;
                m_dvld = 1'b0; m_owner = 2;
            end else if (g == 1) begin
                m_consec = 0; m_ivld = 1'b0; m_owner = 1; m_drop = 1'b0;
            end
        end else if (rsp) begin
            m_owner = 0;
        end else if (m_owner == 1 && fl) begin
            m_drop = 1'b1;
        end
        if (fl) m_ivld = 1'b0;
        if (im != 4'h0) begin m_ivld = 1'b1; m_iaddr = ia; end
        if (drm != 4'h0 || dwm != 4'h0) begin
            m_dvld = 1'b1; m_daddr = da; m_drm = drm; m_dwm = dwm; m_dwd = wd;
        end
        m_granted = g;

        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, 4'h0, '0, 4'h0, 4'h0, '0, '0, 1'b0, '0);
    endtask

    task automatic respond(input logic [31:0] rd);
        step(1'b0, 4'h0, '0, 4'h0, 4'h0, '0, '0, 1'b1, rd);
    endtask

    task automatic drain();
        for (int k = 0; k < 12; k++) begin
            if (!m_ivld && !m_dvld && m_owner == 0) break;
            step(1'b0, 4'h0, '0, 4'h0, 4'h0, '0, '0, m_owner != 0, $urandom);
        end
    endtask

    initial begin
        int   n_dg;
        logic got_i, fl, rsp, ifree, dfree;
        logic [3:0] im, drm, dwm;

        do_reset();
        do_reset();

        // Reset state
        idle();
        check("reset_busy", 32'(o_busy), 32'h0);
        check("reset_rmask", 32'(o_rmask), 32'h0);
        check("reset_wmask", 32'(o_wmask), 32'h0);

        // Single fetch
        step(1'b0, 4'hF, 32'h1eceb000, 4'h0, 4'h0, '0, '0, 1'b0, '0);
        idle();
        check("fetch_rmask", 32'(o_rmask), 32'h0000000F);
        check("fetch_addr", o_addr, 32'h1eceb000);
        idle();
        check("fetch_busy", 32'(o_busy), 32'h1);
        idle();
        respond(32'h00000013);
        check("fetch_iresp", 32'(o_iresp), 32'h1);
        check("fetch_irdata", o_irdata, 32'h00000013);
        idle();
        check("fetch_done_busy", 32'(o_busy), 32'h0);

        // Simultaneous fetch and data write: data first
        step(1'b0, 4'hF, 32'h100, 4'h0, 4'hF, 32'h200, 32'hDEADBEEF, 1'b0, '0);
        idle();
        check("simul_wmask", 32'(o_wmask), 32'h0000000F);
        check("simul_wdata", o_wdata, 32'hDEADBEEF);
        check("simul_waddr", o_addr, 32'h200);
        respond(32'h0);
        check("simul_dresp", 32'(o_dresp), 32'h1);
        idle();
        check("simul_i_rmask", 32'(o_rmask), 32'h0000000F);
        check("simul_i_addr", o_addr, 32'h100);
        respond(32'h12345678);
        check("simul_iresp", 32'(o_iresp), 32'h1);

        // Starvation limit, twice in a row to show the count restarts after a fetch grant
        step(1'b0, 4'hF, 32'h400, 4'hF, 4'h0, 32'h500, '0, 1'b0, '0);
        for (int round = 0; round < 2; round++) begin
            n_dg  = 0;
            got_i = 1'b0;
            for (int k = 0; k < 12; k++) begin
                idle();
                if (o_rmask != 4'h0 && o_addr == 32'h500) begin
                    n_dg++;
                    step(1'b0, 4'h0, '0, 4'hF, 4'h0, 32'h500, '0, 1'b1, $urandom);
                end else if (o_rmask != 4'h0 && o_addr == 32'h400) begin
                    got_i = 1'b1;
                    step(1'b0, (round == 0) ? 4'hF : 4'h0, 32'h400, 4'h0, 4'h0, '0, '0, 1'b1, $urandom);
                    break;
                end else begin
                    break;
                end
            end
            check("starve_d_grants", n_dg, STARVE_LIMIT);
            check("starve_i_granted", 32'(got_i), 32'h1);
        end
        drain();

        // Flush while the fetch is in flight, with a new fetch in the same cycle
        step(1'b0, 4'hF, 32'h100, 4'h0, 4'h0, '0, '0, 1'b0, '0);
        idle();
        step(1'b1, 4'hF, 32'h300, 4'h0, 4'h0, '0, '0, 1'b0, '0);
        respond(32'hAAAA0100);
        check("flush_drop_iresp", 32'(o_iresp), 32'h0);
        idle();
        check("flush_new_addr", o_addr, 32'h300);
        check("flush_new_rmask", 32'(o_rmask), 32'h0000000F);
        respond(32'hBBBB0300);
        check("flush_new_iresp", 32'(o_iresp), 32'h1);
        check("flush_new_irdata", o_irdata, 32'hBBBB0300);

        // Flush of a buffered fetch waiting behind data
        step(1'b0, 4'h0, '0, 4'h0, 4'h3, 32'h600, 32'h0000CAFE, 1'b0, '0);
        step(1'b0, 4'hF, 32'h700, 4'h0, 4'h0, '0, '0, 1'b0, '0);
        step(1'b1, 4'h0, '0, 4'h0, 4'h0, '0, '0, 1'b0, '0);
        respond(32'h0);
        check("bufflush_dresp", 32'(o_dresp), 32'h1);
        idle();
        check("bufflush_rmask", 32'(o_rmask), 32'h0);
        idle();
        check("bufflush_rmask2", 32'(o_rmask), 32'h0);

        // Reset during a data transaction, then a stray response
        step(1'b0, 4'h0, '0, 4'hF, 4'h0, 32'h800, '0, 1'b0, '0);
        idle();
        idle();
        do_reset();
        respond(32'h55555555);
        check("rst_stray_dresp", 32'(o_dresp), 32'h0);
        check("rst_stray_busy", 32'(o_busy), 32'h0);
        check("rst_stray_rmask", 32'(o_rmask), 32'h0);
        check("rst_stray_wmask", 32'(o_wmask), 32'h0);

        // Randomized traffic obeying the requester rules
        for (int n = 0; n < 3000; n++) begin
            rsp   = (m_owner != 0) && (m_wait == 0);
            fl    = ($urandom_range(0, 9) == 0);
            ifree = fl || (!m_ivld && !(m_owner == 1 && !m_drop && !rsp));
            dfree = !m_dvld && !(m_owner == 2 && !rsp);
            im    = (ifree && $urandom_range(0, 2) == 0) ? 4'hF : 4'h0;
            drm   = 4'h0;
            dwm   = 4'h0;
            if (dfree && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) drm = 4'($urandom_range(1, 15));
                else                           dwm = 4'($urandom_range(1, 15));
            end
            step(fl, im, $urandom, drm, dwm, $urandom, $urandom, rsp, $urandom);
            if (m_granted != 0) m_wait = $urandom_range(0, 3);
            else if (m_owner != 0) m_wait--;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
